// File: rtl/cache_ctrl_pkg.sv
// Shared types and sizing helpers for the direct-mapped cache sequencing controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    FILL,
    WR_CACHE,
    WR_MEM,
    RESP
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 15;

  // Counter must be able to hold the value MEM_TIMEOUT itself.
  function automatic int tmo_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int TMO_W = tmo_width(DEF_MEM_TIMEOUT);

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module cache_ctrl_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencer for a direct-mapped, one-word-per-line cache: lookup, read-miss fill,
// write-through allocate, bounded memory wait and hit/miss statistics.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_req_ready,
  output logic                  cpu_resp_valid,
  output logic                  cpu_resp_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_re,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int TW = tmo_width(MEM_TIMEOUT);

  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [TW-1:0]         tmo_q;
  logic                  tmo_last;
  logic                  hit_inc;
  logic                  miss_inc;

  // The current wait cycle is the last one allowed if it brings no ack.
  assign tmo_last = (tmo_q == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt           = state;
    cpu_req_ready = 1'b0;
    cache_re      = 1'b0;
    cache_we      = 1'b0;
    cache_wdata   = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) nxt = cpu_req_we ? WR_CACHE : LOOKUP;
      end
      LOOKUP: begin
        cache_re = 1'b1;
        hit_inc  = cache_hit;
        miss_inc = !cache_hit;
        nxt      = cache_hit ? RESP : MEM_RD;
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack)       nxt = FILL;
        else if (tmo_last) nxt = RESP;
      end
      FILL: begin
        cache_we    = 1'b1;
        cache_wdata = rdata_q;
        nxt         = RESP;
      end
      WR_CACHE: begin
        cache_we    = 1'b1;
        cache_wdata = wdata_q;
        nxt         = WR_MEM;
      end
      WR_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack || tmo_last) nxt = RESP;
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Request latches; rdata/err are cleared at acceptance so writes and
  // errored reads respond with zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        LOOKUP: begin
          if (cache_hit) rdata_q <= cache_rdata;
          else           tmo_q   <= '0;
        end
        WR_CACHE: tmo_q <= '0;
        MEM_RD, WR_MEM: begin
          if (mem_ack) begin
            if (state == MEM_RD) rdata_q <= mem_rdata;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (tmo_last) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_resp_valid = (state == RESP);
  assign cpu_resp_err   = err_q;
  assign cpu_rdata      = (state == RESP) ? rdata_q : '0;
  assign cache_addr     = addr_q;

  cache_ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .clr   (cnt_clr),
    .count (hit_count)
  );

  cache_ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .clr   (cnt_clr),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache/memory environment plus a
// transaction-level reference model of expected responses, latency and counters.
module tb_cache_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int T  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_req_ready, cpu_resp_valid, cpu_resp_err;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] cache_addr;
  logic          cache_re, cache_we;
  logic [DW-1:0] cache_wdata;
  logic          cache_hit;
  logic [DW-1:0] cache_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  // environment: the cache array and backing memory the controller drives
  logic          cv [256];
  logic [DW-1:0] cd [256];
  logic [DW-1:0] mm [256];
  // reference model state
  logic          rv [256];
  logic [DW-1:0] rd [256];
  logic [DW-1:0] rm [256];
  int            ref_hits, ref_misses;
  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  assign cache_hit   = cv[cache_addr];
  assign cache_rdata = cd[cache_addr];

  cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_err(cpu_resp_err), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_re(cache_re), .cache_we(cache_we),
    .cache_wdata(cache_wdata), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cnt_clr(cnt_clr), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check_counters(input string tag);
    checks++;
    if (hit_count !== CW'(ref_hits)) begin
      errors++; $display("FAIL %s hit_count got %0d exp %0d", tag, hit_count, ref_hits);
    end
    checks++;
    if (miss_count !== CW'(ref_misses)) begin
      errors++; $display("FAIL %s miss_count got %0d exp %0d", tag, miss_count, ref_misses);
    end
  endtask

  // One complete CPU transaction; k is the MEM cycle carrying mem_ack (k > T: never).
  task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int k, input logic clr_l);
    int exp_lat, exp_mcyc, exp_wcyc, n, mcnt, wcnt;
    logic exp_err, done;
    logic [DW-1:0] exp_fill;
    exp_mcyc = 0; exp_wcyc = 0; exp_err = 1'b0; exp_fill = '0;
    if (!we) begin
      if (rv[a]) begin
        exp_q.push_back(rd[a]); exp_lat = 2;
        if (ref_hits < MAXC) ref_hits++;
      end else begin
        if (ref_misses < MAXC) ref_misses++;
        exp_mcyc = (k <= T) ? k : T;
        if (k <= T) begin
          exp_q.push_back(rm[a]); exp_fill = rm[a]; exp_wcyc = 1; exp_lat = 3 + k;
          rv[a] = 1'b1; rd[a] = rm[a];
        end else begin
          exp_q.push_back('0); exp_err = 1'b1; exp_lat = T + 2;
        end
      end
    end else begin
      exp_q.push_back('0); exp_fill = wd; exp_wcyc = 1;
      rv[a] = 1'b1; rd[a] = wd;
      exp_mcyc = (k <= T) ? k : T;
      if (k <= T) begin rm[a] = wd; exp_lat = 2 + k; end
      else begin exp_err = 1'b1; exp_lat = T + 2; end
    end
    if (clr_l) begin ref_hits = 0; ref_misses = 0; end

    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL ready_idle got %b exp 1", cpu_req_ready); end
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_addr = a; cpu_wdata = wd;
    mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = DW'($urandom);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0; cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
    n = 0; mcnt = 0; wcnt = 0; done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk); n++;
      cnt_clr = clr_l && (n == 1);
      if (cpu_req_ready !== 1'b0 || (cache_re && cache_we)) begin
        errors++; $display("FAIL busy_strobes ready %b re %b we %b", cpu_req_ready, cache_re, cache_we);
      end
      if (cache_we) begin
        wcnt++; checks++;
        if (cache_addr !== a || cache_wdata !== exp_fill) begin
          errors++; $display("FAIL cache_write got %h/%h exp %h/%h", cache_addr, cache_wdata, a, exp_fill);
        end
        cv[cache_addr] = 1'b1; cd[cache_addr] = cache_wdata;
      end
      if (mem_req) begin
        mcnt++; checks++;
        if (mem_addr !== a || mem_we !== we || (we && mem_wdata !== wd)) begin
          errors++; $display("FAIL mem_cmd got %h/%b/%h exp %h/%b/%h", mem_addr, mem_we, mem_wdata, a, we, wd);
        end
        mem_ack = (mcnt == k);
        mem_rdata = DW'($urandom);
        if (mem_ack) begin
          if (mem_we) mm[mem_addr] = mem_wdata;
          else        mem_rdata = mm[mem_addr];
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = DW'($urandom);
      end
      if (cpu_resp_valid) begin
        done = 1'b1;
        checks++;
        if (n != exp_lat) begin errors++; $display("FAIL latency got %0d exp %0d", n, exp_lat); end
        checks++;
        if (cpu_rdata !== exp_q[0]) begin errors++; $display("FAIL rdata got %h exp %h", cpu_rdata, exp_q[0]); end
        void'(exp_q.pop_front());
        checks++;
        if (cpu_resp_err !== exp_err) begin errors++; $display("FAIL err got %b exp %b", cpu_resp_err, exp_err); end
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL resp_timeout no cpu_resp_valid within %0d cycles", n); end
    checks++;
    if (mcnt != exp_mcyc || wcnt != exp_wcyc) begin
      errors++; $display("FAIL cycles mem_req %0d cache_we %0d exp %0d %0d", mcnt, wcnt, exp_mcyc, exp_wcyc);
    end
    @(negedge clk);
    cnt_clr = 1'b0; mem_ack = 1'b0;
    checks++;
    if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
      errors++; $display("FAIL resp_pulse valid %b ready %b exp 0 1", cpu_resp_valid, cpu_req_ready);
    end
    check_counters("txn");
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_req_ready, cpu_resp_valid, cpu_resp_err, cache_re, cache_we, mem_req, mem_we} !== 7'b1000000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 1000000",
        {cpu_req_ready, cpu_resp_valid, cpu_resp_err, cache_re, cache_we, mem_req, mem_we});
    end
    checks++;
    if ({cpu_rdata, cache_addr, cache_wdata, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {cpu_rdata, cache_addr, cache_wdata, mem_addr, mem_wdata});
    end
    check_counters("reset");
    rst = 1'b1;
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_addr = 8'h9A;
    @(posedge clk); #1 cpu_req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req got %b exp 1", mem_req); end
    @(negedge clk); #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || cpu_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset mem_req %b ready %b exp 0 1", mem_req, cpu_req_ready);
    end
    ref_hits = 0; ref_misses = 0;
    check_counters("mid_reset");
    @(negedge clk) rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
        errors++; $display("FAIL post_reset valid %b ready %b exp 0 1", cpu_resp_valid, cpu_req_ready);
      end
    end
  endtask

  task automatic test_read_hit;
    cv[8'h12] = 1'b1; cd[8'h12] = 8'hAB; rv[8'h12] = 1'b1; rd[8'h12] = 8'hAB;
    do_txn(1'b0, 8'h12, 8'h00, 1, 1'b0);
  endtask

  task automatic test_read_miss;
    mm[8'h34] = 8'h5C; rm[8'h34] = 8'h5C;
    do_txn(1'b0, 8'h34, 8'h00, 3, 1'b0);
  endtask

  task automatic test_write;
    do_txn(1'b1, 8'h40, 8'h77, 2, 1'b0);
  endtask

  task automatic test_timeout;
    do_txn(1'b0, 8'h50, 8'h00, 99, 1'b0);
    do_txn(1'b0, 8'h51, 8'h00, T, 1'b0);
    do_txn(1'b1, 8'h52, 8'h3C, 99, 1'b0);
  endtask

  task automatic test_saturation;
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
    ref_hits = 0; ref_misses = 0;
    do_txn(1'b1, 8'h20, 8'hE1, 1, 1'b0);
    for (int i = 0; i < 16; i++) do_txn(1'b0, 8'h20, 8'h00, 1, 1'b0);
    checks++;
    if (hit_count !== 4'd15) begin errors++; $display("FAIL saturate got %0d exp 15", hit_count); end
    do_txn(1'b0, 8'h20, 8'h00, 1, 1'b1);
    checks++;
    if (hit_count !== 4'd0) begin errors++; $display("FAIL clr_priority got %0d exp 0", hit_count); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      do_txn(1'($urandom_range(0, 1)), AW'(8'hC0 + $urandom_range(0, 7)), DW'($urandom),
             $urandom_range(1, T + 2), ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      cv[i] = 1'b0; rv[i] = 1'b0; cd[i] = '0; rd[i] = '0;
      mm[i] = DW'($urandom); rm[i] = mm[i];
    end
    ref_hits = 0; ref_misses = 0;
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write();
    test_timeout();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the single-level direct-mapped cache.
- Accepts one CPU request at a time via a valid/ready handshake and drives the cache array's lookup and write enables.
- Fetches read misses from backing memory with a req/ack handshake and write-through-allocates on writes.
- Returns a one-cycle response pulse and keeps saturating hit/miss statistics counters.

Parameters:
- ADDR_WIDTH, 8, CPU/cache/memory address width.
- DATA_WIDTH, 8, data word width (one word per line).
- CNT_WIDTH, 16, width of the hit and miss counters.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- cpu_req_valid  in  1  request present.
- cpu_req_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_WIDTH  request address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_err  out  1  memory timeout on this request; qualified by cpu_resp_valid.
- cpu_rdata  out  DATA_WIDTH  read data; qualified by cpu_resp_valid.
- cache_addr  out  ADDR_WIDTH  address to cache array (latched request address).
- cache_re  out  1  lookup strobe.
- cache_we  out  1  cache write strobe.
- cache_wdata  out  DATA_WIDTH  cache write data.
- cache_hit  in  1  combinational hit for cache_addr, valid while cache_re=1.
- cache_rdata  in  DATA_WIDTH  combinational read data, valid with cache_hit.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  one-cycle memory completion.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- cnt_clr  in  1  synchronous clear of both counters.
- hit_count  out  CNT_WIDTH  read hits.
- miss_count  out  CNT_WIDTH  read misses.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0): state IDLE; all outputs 0 except cpu_req_ready=1; latches and counters 0; timeout counter 0.
- Reset mid-operation: mem_req drops immediately, in-flight request discarded, no response issued.
- Clock edges are numbered with acceptance at edge 0.
- IDLE: cpu_req_ready=1. On valid&ready, latch addr/we/wdata. Go to LOOKUP if read, WR_CACHE if write. cpu_req_ready=0 in every other state.
- LOOKUP (1 cycle): cache_re=1, cache_addr=latched address.
  - Hit: register cache_rdata, hit_count++, go to RESP.
  - Miss: miss_count++, clear timeout counter, go to MEM_RD.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched address.
  - mem_ack: register mem_rdata, go to FILL.
  - Else timeout counter++; reaching MEM_TIMEOUT sets err, goes to RESP, no fill.
- FILL (1 cycle): cache_we=1, cache_wdata=fetched word, go to RESP.
- WR_CACHE (1 cycle): cache_we=1, cache_wdata=latched wdata. Clear timeout counter, go to WR_MEM.
- WR_MEM: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched. Ack/timeout handled as in MEM_RD; both exit to RESP.
- RESP (1 cycle): cpu_resp_valid=1 with cpu_rdata and cpu_resp_err. Next state IDLE. cpu_rdata is 0 for writes and errored reads.
- Latency: read hit resp_valid 2 cycles after acceptance.
  - Read miss with ack on the k-th MEM_RD cycle: resp_valid after 3+k cycles.
  - Write with ack on k-th cycle: resp_valid after 2+k cycles.
- No back-to-back acceptance: the earliest next acceptance is the cycle after RESP.
- mem_ack outside MEM_RD/WR_MEM is ignored.
- mem_ack on the same cycle the timeout would fire: ack wins, err=0.
- cache_hit/cache_rdata are ignored outside LOOKUP.
- cache_we and cache_re are never both 1.
- Counters saturate at 2^CNT_WIDTH-1. Writes do not count.
- cnt_clr has priority over a same-cycle increment; the result is 0.
- Errored request: err stays registered until the next acceptance.

Decomposition:
- Package cache_ctrl_pkg: state enum (IDLE, LOOKUP, MEM_RD, FILL, WR_CACHE, WR_MEM, RESP); shared localparam for the timeout counter width, $clog2(MEM_TIMEOUT+1).
- Sub-module: cache_ctrl_sat_counter (CNT_WIDTH param; inc, clr, count), instantiated twice for hit and miss.

Test Plan:
- Reset: assert rst=0 mid-MEM_RD with mem_req=1 -> mem_req=0 immediately; after release cpu_req_ready=1, counters 0, no resp_valid.
- Read hit: read 0x12, cache_hit=1, cache_rdata=0xAB -> resp_valid 2 cycles after acceptance, rdata=0xAB, err=0, hit_count=1, mem_req never 1.
- Read miss: read 0x34, cache_hit=0, mem_ack on 3rd MEM_RD cycle with mem_rdata=0x5C -> mem_req high 3 cycles, then one cache_we cycle with addr 0x34/wdata 0x5C, then resp rdata=0x5C, miss_count=1.
- Write: write 0x77 to 0x40, ack on 2nd cycle -> one cache_we (0x40, 0x77), then mem_req=mem_we=1 with 0x40/0x77 for 2 cycles, then resp err=0; counters unchanged.
- Timeout: MEM_TIMEOUT=4, read miss, no ack -> mem_req high exactly 4 cycles, no cache_we, resp_valid with err=1, rdata=0. Repeat with ack on cycle 4 -> err=0, fill occurs.
- Saturation/clear: CNT_WIDTH=4, 16 read hits -> hit_count=15. A hit with cnt_clr=1 in its LOOKUP cycle -> hit_count=0.
